// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: parameterised data width, parity and stop bits,
// with a valid/ready input and a one-word holding buffer for gap-free frames.
module uart_tx_cfg #(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int DATA_BITS        = 8,
    parameter int PARITY_EN        = 0,
    parameter int PARITY_ODD       = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    // state  | meaning
    // IDLE   | line high, waiting for a buffered word
    // START  | start bit (low)
    // DATA   | data bits, LSB first
    // PARITY | optional parity bit
    // STOP   | STOP_BITS stop bits (high); reloads directly from the buffer
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int            CW        = $clog2(CLOCKS_PER_PULSE);
    localparam int            IW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] buf_data;
    logic [DATA_BITS-1:0] shreg;
    logic                 buf_full;
    logic                 par_bit;
    logic                 stop_cnt;
    logic [CW-1:0]        bit_cnt;
    logic [IW-1:0]        bit_idx;
    logic                 bit_end;
    logic                 load;
    logic                 tx_nxt;
    logic                 done_nxt;

    assign bit_end    = (bit_cnt == CNT_LAST);
    assign data_ready = !buf_full;
    assign tx_busy    = (state != IDLE) || buf_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (buf_full) state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && bit_idx == IDX_LAST)
                         state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (bit_end && stop_cnt == STOP_LAST)
                         state_nxt = buf_full ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered, so it is given the level of the bit being entered.
    always_comb begin
        tx_nxt   = tx;
        done_nxt = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (buf_full) begin
                    load   = 1'b1;
                    tx_nxt = 1'b0;
                end
            end
            START:  if (bit_end) tx_nxt = shreg[0];
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) tx_nxt = (PARITY_EN != 0) ? par_bit : 1'b1;
                    else                     tx_nxt = shreg[1];
                end
            end
            PARITY: if (bit_end) tx_nxt = 1'b1;
            STOP: begin
                if (bit_end && stop_cnt == STOP_LAST) begin
                    done_nxt = 1'b1;
                    load     = buf_full;
                    tx_nxt   = !buf_full;
                end
            end
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            buf_full <= 1'b0;
            buf_data <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            tx      <= tx_nxt;
            tx_done <= done_nxt;

            if (load) begin
                buf_full <= 1'b0;
            end else if (data_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= data_in;
            end

            // shreg[0] always holds the bit currently on the line during DATA
            if (load) begin
                shreg   <= buf_data;
                par_bit <= (^buf_data) ^ PAR_ODD;
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end

            if (load || state == IDLE || bit_end) bit_cnt <= '0;
            else                                  bit_cnt <= bit_cnt + CW'(1);

            if (load)                          bit_idx <= '0;
            else if (state == DATA && bit_end) bit_idx <= bit_idx + IW'(1);

            if (state != STOP) stop_cnt <= 1'b0;
            else if (bit_end)  stop_cnt <= ~stop_cnt;
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: five instances cover 8N1, 8E1, 8O1, 7N2 and a
// fast 8N1 streaming configuration decoded by a small scoreboard.
module tb_uart_tx_cfg;
    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] dv;
    logic [8:0] din [5];
    logic [4:0] tx_v, busy_v, done_v, rdy_v;
    int         checks = 0;
    int         errors = 0;
    logic       tx_log   [100];
    logic       busy_log [100];
    logic       done_log [100];

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLOCKS_PER_PULSE(4)) u_8n1 (
        .clk(clk), .rstn(rstn), .data_in(din[0][7:0]), .data_valid(dv[0]),
        .data_ready(rdy_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_cfg #(.CLOCKS_PER_PULSE(4), .PARITY_EN(1)) u_8e1 (
        .clk(clk), .rstn(rstn), .data_in(din[1][7:0]), .data_valid(dv[1]),
        .data_ready(rdy_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_cfg #(.CLOCKS_PER_PULSE(4), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clk(clk), .rstn(rstn), .data_in(din[2][7:0]), .data_valid(dv[2]),
        .data_ready(rdy_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_cfg #(.CLOCKS_PER_PULSE(4), .DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rstn(rstn), .data_in(din[3][6:0]), .data_valid(dv[3]),
        .data_ready(rdy_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));
    uart_tx_cfg #(.CLOCKS_PER_PULSE(2)) u_stream (
        .clk(clk), .rstn(rstn), .data_in(din[4][7:0]), .data_valid(dv[4]),
        .data_ready(rdy_v[4]), .tx(tx_v[4]), .tx_busy(busy_v[4]), .tx_done(done_v[4]));

    // All tasks start and end 1 time unit after a rising edge.
    task automatic accept(input int u, input logic [8:0] w);
        int n;
        n = 0;
        dv[u] = 1'b1;
        din[u] = w;
        while (rdy_v[u] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL accept_timeout unit %0d: data_ready=%b, required 1", u, rdy_v[u]);
        end
        @(posedge clk); #1;
        dv[u] = 1'b0;
        din[u] = ~w;
    endtask

    task automatic capture(input int u, input int base, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            tx_log[base+c]   = tx_v[u];
            busy_log[base+c] = busy_v[u];
            done_log[base+c] = done_v[u];
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        dv = '0;
        for (int i = 0; i < 5; i++) din[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_v !== 5'h1F) begin errors++; $display("FAIL reset_tx: got %b, required 11111", tx_v); end
        checks++;
        if (busy_v !== 5'h00) begin errors++; $display("FAIL reset_busy: got %b, required 00000", busy_v); end
        checks++;
        if (done_v !== 5'h00) begin errors++; $display("FAIL reset_done: got %b, required 00000", done_v); end
        checks++;
        if (rdy_v !== 5'h1F) begin errors++; $display("FAIL reset_ready: got %b, required 11111", rdy_v); end
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx_v !== 5'h1F || busy_v !== 5'h00) begin
            errors++;
            $display("FAIL idle_after_reset: tx=%b busy=%b, required 11111/00000", tx_v, busy_v);
        end
    endtask

    // Frame vectors are written bit0 (start) rightmost.
    task automatic test_frames();
        logic [8:0]  words  [4];
        logic [15:0] frames [4];
        int          nbits  [4];
        int          u, len, bad_busy, bad_done;
        logic [15:0] f;
        words  = '{9'h0A5, 9'h0A5, 9'h0A5, 9'h1FF};
        frames = '{16'b1101001010, 16'b10101001010, 16'b11101001010, 16'b1111111110};
        nbits  = '{10, 11, 11, 10};
        for (int t = 0; t < 4; t++) begin
            u   = t;
            f   = frames[t];
            len = nbits[t] * 4;
            accept(u, words[t]);
            checks++;
            if (tx_v[u] !== 1'b1 || busy_v[u] !== 1'b1) begin
                errors++;
                $display("FAIL accept_edge unit %0d: tx=%b busy=%b, required 1/1", u, tx_v[u], busy_v[u]);
            end
            capture(u, 0, len + 2);
            checks++;
            if (tx_log[0] !== 1'b0) begin
                errors++;
                $display("FAIL start_latency unit %0d: tx=%b one cycle after accept, required 0", u, tx_log[0]);
            end
            bad_busy = 0;
            bad_done = 0;
            for (int c = 0; c < len; c++) begin
                checks++;
                if (tx_log[c] !== f[c/4]) begin
                    errors++;
                    $display("FAIL frame_bit unit %0d cycle %0d: tx=%b, required %b", u, c, tx_log[c], f[c/4]);
                end
                if (busy_log[c] !== 1'b1) bad_busy++;
                if (done_log[c] !== 1'b0) bad_done++;
            end
            checks++;
            if (bad_busy != 0) begin
                errors++;
                $display("FAIL frame_busy unit %0d: %0d cycles with tx_busy low, required 0", u, bad_busy);
            end
            checks++;
            if (bad_done != 0) begin
                errors++;
                $display("FAIL early_done unit %0d: %0d early tx_done cycles, required 0", u, bad_done);
            end
            checks++;
            if (done_log[len] !== 1'b1 || tx_log[len] !== 1'b1 || busy_log[len] !== 1'b0) begin
                errors++;
                $display("FAIL frame_end unit %0d: done=%b tx=%b busy=%b, required 1/1/0",
                         u, done_log[len], tx_log[len], busy_log[len]);
            end
            checks++;
            if (done_log[len+1] !== 1'b0) begin
                errors++;
                $display("FAIL done_width unit %0d: tx_done=%b second cycle, required 0", u, done_log[len+1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] f;
        int          bad_busy, bad_done;
        f = {10'b1000011110, 10'b1010101010};
        dv[0] = 1'b1;
        din[0] = 9'h055;
        @(posedge clk); #1;
        din[0] = 9'h00F;
        checks++;
        if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_first_full: data_ready=%b, required 0", rdy_v[0]); end
        capture(0, 0, 1);
        checks++;
        if (rdy_v[0] !== 1'b1) begin errors++; $display("FAIL b2b_reload_ready: data_ready=%b, required 1", rdy_v[0]); end
        capture(0, 1, 1);
        dv[0] = 1'b0;
        din[0] = 9'h1AA;
        checks++;
        if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_second_full: data_ready=%b, required 0", rdy_v[0]); end
        capture(0, 2, 80);
        bad_busy = 0;
        bad_done = 0;
        for (int c = 0; c < 80; c++) begin
            checks++;
            if (tx_log[c] !== f[c/4]) begin
                errors++;
                $display("FAIL b2b_bit cycle %0d: tx=%b, required %b", c, tx_log[c], f[c/4]);
            end
            if (busy_log[c] !== 1'b1) bad_busy++;
            if (done_log[c] !== (c == 40)) bad_done++;
        end
        checks++;
        if (tx_log[39] !== 1'b1 || tx_log[40] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap: tx at 39/40=%b%b, required 10", tx_log[39], tx_log[40]);
        end
        checks++;
        if (bad_busy != 0) begin errors++; $display("FAIL b2b_busy: %0d low cycles, required 0", bad_busy); end
        checks++;
        if (bad_done != 0) begin errors++; $display("FAIL b2b_done_first: %0d wrong cycles, required 0", bad_done); end
        checks++;
        if (done_log[80] !== 1'b1 || done_log[81] !== 1'b0 || busy_log[80] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_second: done80=%b done81=%b busy80=%b, required 1/0/0",
                     done_log[80], done_log[81], busy_log[80]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad_tx, bad_busy;
        dv[0] = 1'b1;
        din[0] = 9'h032;
        @(posedge clk); #1;
        din[0] = 9'h044;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dv[0] = 1'b0;
        checks++;
        if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL rst_buffered: data_ready=%b, required 0", rdy_v[0]); end
        repeat (6) begin @(posedge clk); #1; end
        checks++;
        if (tx_v[0] !== 1'b0) begin errors++; $display("FAIL rst_pre_data: tx=%b, required 0", tx_v[0]); end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (tx_v[0] !== 1'b1) begin errors++; $display("FAIL rst_async_tx: tx=%b, required 1", tx_v[0]); end
        checks++;
        if (rdy_v[0] !== 1'b1) begin errors++; $display("FAIL rst_async_ready: data_ready=%b, required 1", rdy_v[0]); end
        checks++;
        if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL rst_async_busy: tx_busy=%b, required 0", busy_v[0]); end
        dv[0] = 1'b1;
        din[0] = 9'h099;
        repeat (3) begin @(posedge clk); #1; end
        dv[0] = 1'b0;
        rstn = 1'b1;
        bad_tx = 0;
        bad_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (tx_v[0] !== 1'b1) bad_tx++;
            if (busy_v[0] !== 1'b0) bad_busy++;
        end
        checks++;
        if (bad_tx != 0) begin errors++; $display("FAIL rst_no_tx: %0d low cycles after release, required 0", bad_tx); end
        checks++;
        if (bad_busy != 0) begin errors++; $display("FAIL rst_no_busy: %0d busy cycles after release, required 0", bad_busy); end
    endtask

    task automatic test_stream();
        logic [7:0] words [20];
        logic [7:0] sh;
        int         sent, got, in_frame, s, last_s, dones, o, bad_tx;
        bit         acc;
        for (int k = 0; k < 20; k++) words[k] = 8'(k * 37 + 5);
        sent = 0; got = 0; in_frame = 0; s = 0; last_s = -1; dones = 0; sh = '0;
        din[4] = {1'b0, words[0]};
        dv[4] = 1'b1;
        for (int cyc = 0; cyc < 1000 && got < 20; cyc++) begin
            acc = dv[4] && rdy_v[4];
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 20) din[4] = {1'b0, words[sent]};
                else           dv[4] = 1'b0;
            end
            if (done_v[4] === 1'b1) dones++;
            if (in_frame == 0) begin
                if (tx_v[4] === 1'b0) begin
                    in_frame = 1;
                    s = cyc;
                    if (last_s >= 0) begin
                        checks++;
                        if (cyc - last_s != 20) begin
                            errors++;
                            $display("FAIL stream_gap word %0d: start spacing %0d, required 20", got, cyc - last_s);
                        end
                    end
                    last_s = cyc;
                end
            end else begin
                o = cyc - s;
                if (o >= 2 && o <= 17 && (o % 2) == 0) sh[o/2-1] = tx_v[4];
                if (o == 18 || o == 19) begin
                    checks++;
                    if (tx_v[4] !== 1'b1) begin
                        errors++;
                        $display("FAIL stream_stop word %0d: tx=%b, required 1", got, tx_v[4]);
                    end
                end
                if (o == 19) begin
                    checks++;
                    if (sh !== words[got]) begin
                        errors++;
                        $display("FAIL stream_word %0d: decoded %h, required %h", got, sh, words[got]);
                    end
                    got++;
                    in_frame = 0;
                end
            end
        end
        bad_tx = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done_v[4] === 1'b1) dones++;
            if (tx_v[4] !== 1'b1) bad_tx++;
        end
        checks++;
        if (got != 20) begin errors++; $display("FAIL stream_count: decoded %0d words, required 20", got); end
        checks++;
        if (dones != 20) begin errors++; $display("FAIL stream_done: %0d tx_done pulses, required 20", dones); end
        checks++;
        if (bad_tx != 0) begin errors++; $display("FAIL stream_extra: %0d low cycles after last word, required 0", bad_tx); end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
